regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_if.sv | 24 ++
 rtl/regfile_read_port.sv | 36 +++
 rtl/regfile.sv | 75 +++++++
 tb/tb_regfile.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register file: default geometry and the hardwired zero register.
// Latency: n/a (constants only); no backpressure.
package regfile_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DEPTH_DEF      = 1 << ADDR_WIDTH_DEF;
    localparam int ZERO_REG       = 0;

    function automatic int rf_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Register-file access bundle: one write port and two read ports.
// Latency: reads combinational, writes land on the next rising edge; no backpressure.
interface regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] address_read_1;
    logic [ADDR_WIDTH-1:0] address_read_2;
    logic [ADDR_WIDTH-1:0] address_write;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic [DATA_WIDTH-1:0] read_data_2;

    modport master (
        output write_enable, address_read_1, address_read_2, address_write, write_data,
        input  read_data_1, read_data_2
    );

    modport slave (
        input  write_enable, address_read_1, address_read_2, address_write, write_data,
        output read_data_1, read_data_2
    );
endinterface

// File: rtl/regfile_read_port.sv
// One read port: register select mux, zero-register override, optional forwarding (REGFILE_BYPASS_EN).
// Latency: fully combinational; no backpressure.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = rf_depth(ADDR_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] regs [DEPTH],
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  fwd_vld,
    input  logic [ADDR_WIDTH-1:0] fwd_addr,
    input  logic [DATA_WIDTH-1:0] fwd_dat,
    output logic [DATA_WIDTH-1:0] rd_dat
);

    always_comb begin
        rd_dat = regs[rd_addr];
`ifdef REGFILE_BYPASS_EN
        if (fwd_vld && (fwd_addr == rd_addr)) begin
            rd_dat = fwd_dat;
        end
`endif
        // Zero check last so neither storage nor forwarding can leak into x0.
        if (rd_addr == ADDR_WIDTH'(ZERO_REG)) begin
            rd_dat = '0;
        end
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_fwd;
    assign unused_fwd = ^{fwd_vld, fwd_addr, fwd_dat};
`endif

endmodule

// File: rtl/regfile.sv
// 2-read/1-write register file, x0 hardwired to zero; REGFILE_BYPASS_EN adds write-to-read forwarding.
// Latency: comb reads, writes visible after the rising edge; no backpressure.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address_read_1,
    input  logic [ADDR_WIDTH-1:0] address_read_2,
    input  logic [ADDR_WIDTH-1:0] address_write,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2
);

    localparam int DEPTH = rf_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic                  wr_vld;

    assign wr_vld = write_enable && (address_write != ADDR_WIDTH'(ZERO_REG));

    always_comb begin
        regs_d = regs_q;
        if (wr_vld) begin
            regs_d[address_write] = write_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Forwarding is squashed during reset so outputs stay zero while reset_n is low.
    logic fwd_vld;
    assign fwd_vld = wr_vld && reset_n;

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_rd_port_1 (
        .regs     (regs_q),
        .rd_addr  (address_read_1),
        .fwd_vld  (fwd_vld),
        .fwd_addr (address_write),
        .fwd_dat  (write_data),
        .rd_dat   (read_data_1)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_rd_port_2 (
        .regs     (regs_q),
        .rd_addr  (address_read_2),
        .fwd_vld  (fwd_vld),
        .fwd_addr (address_write),
        .fwd_dat  (write_data),
        .rd_dat   (read_data_2)
    );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: scoreboard of expected read values, one task per scenario.
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clock;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] sb_q [$];
    logic [31:0] exp_v;

    regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .write_enable   (bus.write_enable),
        .address_read_1 (bus.address_read_1),
        .address_read_2 (bus.address_read_2),
        .address_write  (bus.address_write),
        .write_data     (bus.write_data),
        .read_data_1    (bus.read_data_1),
        .read_data_2    (bus.read_data_2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        @(negedge clock);
        reset_n = 1'b1;
        bus.address_read_1 = 5'd1;
        bus.address_read_2 = 5'd31;
        sb_q.push_back(32'd0);
        sb_q.push_back(32'd0);
        #1;
        exp_v = sb_q.pop_front(); n_cmp++;
        if (bus.read_data_1 !== exp_v) begin n_err++; $display("FAIL reset_rd1: got %h want %h", bus.read_data_1, exp_v); end
        exp_v = sb_q.pop_front(); n_cmp++;
        if (bus.read_data_2 !== exp_v) begin n_err++; $display("FAIL reset_rd2: got %h want %h", bus.read_data_2, exp_v); end
    endtask

    // Data glitches mid-cycle before settling; only the edge value may be stored.
    task automatic test_write_all();
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            bus.write_enable  = 1'b1;
            bus.address_write = 5'(i);
            bus.write_data    = 32'hFFFF_FFFF;
            #2;
            bus.write_data    = 32'(i + 100);
        end
        @(negedge clock);
        bus.write_enable = 1'b0;
    endtask

    task automatic test_read_pairs();
        logic [4:0]  a1 [4];
        logic [4:0]  a2 [4];
        logic [31:0] e1 [4];
        logic [31:0] e2 [4];
        a1 = '{5'd1, 5'd4, 5'd31, 5'd6};
        a2 = '{5'd2, 5'd5, 5'd31, 5'd30};
        e1 = '{32'd101, 32'd104, 32'd131, 32'd106};
        e2 = '{32'd102, 32'd105, 32'd131, 32'd130};
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            bus.address_read_1 = a1[k];
            bus.address_read_2 = a2[k];
            sb_q.push_back(e1[k]);
            sb_q.push_back(e2[k]);
            #1;
            exp_v = sb_q.pop_front(); n_cmp++;
            if (bus.read_data_1 !== exp_v) begin n_err++; $display("FAIL pair%0d_rd1: got %h want %h", k, bus.read_data_1, exp_v); end
            exp_v = sb_q.pop_front(); n_cmp++;
            if (bus.read_data_2 !== exp_v) begin n_err++; $display("FAIL pair%0d_rd2: got %h want %h", k, bus.read_data_2, exp_v); end
        end
    endtask

    task automatic test_sweep(input bit after_reset);
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            bus.address_read_1 = 5'(i);
            bus.address_read_2 = 5'(31 - i);
            sb_q.push_back((after_reset || i == 0) ? 32'd0 : 32'(i + 100));
            sb_q.push_back((after_reset || i == 31) ? 32'd0 : 32'(131 - i));
            #1;
            exp_v = sb_q.pop_front(); n_cmp++;
            if (bus.read_data_1 !== exp_v) begin n_err++; $display("FAIL sweep%0d_rd1[%0d]: got %h want %h", after_reset, i, bus.read_data_1, exp_v); end
            exp_v = sb_q.pop_front(); n_cmp++;
            if (bus.read_data_2 !== exp_v) begin n_err++; $display("FAIL sweep%0d_rd2[%0d]: got %h want %h", after_reset, 31 - i, bus.read_data_2, exp_v); end
        end
    endtask

    // Concurrent write to x0 must neither store nor forward.
    task automatic test_zero_reg();
        @(negedge clock);
        bus.write_enable   = 1'b1;
        bus.address_write  = 5'd0;
        bus.write_data     = 32'hCAFE_F00D;
        bus.address_read_1 = 5'd0;
        bus.address_read_2 = 5'd31;
        sb_q.push_back(32'd0);
        sb_q.push_back(32'd131);
        #1;
        exp_v = sb_q.pop_front(); n_cmp++;
        if (bus.read_data_1 !== exp_v) begin n_err++; $display("FAIL x0_pre_rd1: got %h want %h", bus.read_data_1, exp_v); end
        exp_v = sb_q.pop_front(); n_cmp++;
        if (bus.read_data_2 !== exp_v) begin n_err++; $display("FAIL x0_pre_rd2: got %h want %h", bus.read_data_2, exp_v); end
        @(posedge clock); #1;
        bus.write_enable = 1'b0;
        sb_q.push_back(32'd0);
        #1;
        exp_v = sb_q.pop_front(); n_cmp++;
        if (bus.read_data_1 !== exp_v) begin n_err++; $display("FAIL x0_post_rd1: got %h want %h", bus.read_data_1, exp_v); end
    endtask

    task automatic test_write_disable();
        @(negedge clock);
        bus.write_enable   = 1'b0;
        bus.address_write  = 5'd3;
        bus.write_data     = 32'hDEAD_BEEF;
        bus.address_read_1 = 5'd3;
        bus.address_read_2 = 5'd3;
        @(posedge clock); #1;
        sb_q.push_back(32'd103);
        sb_q.push_back(32'd103);
        exp_v = sb_q.pop_front(); n_cmp++;
        if (bus.read_data_1 !== exp_v) begin n_err++; $display("FAIL we0_rd1: got %h want %h", bus.read_data_1, exp_v); end
        exp_v = sb_q.pop_front(); n_cmp++;
        if (bus.read_data_2 !== exp_v) begin n_err++; $display("FAIL we0_rd2: got %h want %h", bus.read_data_2, exp_v); end
    endtask

    task automatic test_same_cycle();
        @(negedge clock);
        bus.write_enable   = 1'b1;
        bus.address_write  = 5'd7;
        bus.write_data     = 32'h55;
        bus.address_read_1 = 5'd7;
        bus.address_read_2 = 5'd7;
        sb_q.push_back(BYPASS ? 32'h55 : 32'd107);
        sb_q.push_back(BYPASS ? 32'h55 : 32'd107);
        #1;
        exp_v = sb_q.pop_front(); n_cmp++;
        if (bus.read_data_1 !== exp_v) begin n_err++; $display("FAIL same_pre_rd1: got %h want %h", bus.read_data_1, exp_v); end
        exp_v = sb_q.pop_front(); n_cmp++;
        if (bus.read_data_2 !== exp_v) begin n_err++; $display("FAIL same_pre_rd2: got %h want %h", bus.read_data_2, exp_v); end
        @(posedge clock); #1;
        bus.write_enable = 1'b0;
        sb_q.push_back(32'h55);
        sb_q.push_back(32'h55);
        #1;
        exp_v = sb_q.pop_front(); n_cmp++;
        if (bus.read_data_1 !== exp_v) begin n_err++; $display("FAIL same_post_rd1: got %h want %h", bus.read_data_1, exp_v); end
        exp_v = sb_q.pop_front(); n_cmp++;
        if (bus.read_data_2 !== exp_v) begin n_err++; $display("FAIL same_post_rd2: got %h want %h", bus.read_data_2, exp_v); end
    endtask

    // Reset lands between edges with a write pending; that write must be dropped.
    task automatic test_async_reset();
        @(negedge clock);
        bus.address_read_1 = 5'd1;
        bus.address_read_2 = 5'd31;
        bus.write_enable   = 1'b1;
        bus.address_write  = 5'd5;
        bus.write_data     = 32'h1111_2222;
        sb_q.push_back(32'd101);
        sb_q.push_back(32'd131);
        #1;
        exp_v = sb_q.pop_front(); n_cmp++;
        if (bus.read_data_1 !== exp_v) begin n_err++; $display("FAIL prerst_rd1: got %h want %h", bus.read_data_1, exp_v); end
        exp_v = sb_q.pop_front(); n_cmp++;
        if (bus.read_data_2 !== exp_v) begin n_err++; $display("FAIL prerst_rd2: got %h want %h", bus.read_data_2, exp_v); end
        reset_n = 1'b0;
        bus.address_read_2 = 5'd5;
        sb_q.push_back(32'd0);
        sb_q.push_back(32'd0);
        #1;
        exp_v = sb_q.pop_front(); n_cmp++;
        if (bus.read_data_1 !== exp_v) begin n_err++; $display("FAIL rst_now_rd1: got %h want %h", bus.read_data_1, exp_v); end
        exp_v = sb_q.pop_front(); n_cmp++;
        if (bus.read_data_2 !== exp_v) begin n_err++; $display("FAIL rst_now_rd2: got %h want %h", bus.read_data_2, exp_v); end
        @(posedge clock);
        @(negedge clock);
        bus.write_enable = 1'b0;
        reset_n = 1'b1;
        test_sweep(1'b1);
    endtask

    task automatic test_resume();
        @(negedge clock);
        bus.write_enable   = 1'b1;
        bus.address_write  = 5'd9;
        bus.write_data     = 32'h0000_1234;
        bus.address_read_1 = 5'd9;
        bus.address_read_2 = 5'd10;
        @(posedge clock); #1;
        bus.write_enable = 1'b0;
        sb_q.push_back(32'h1234);
        sb_q.push_back(32'd0);
        #1;
        exp_v = sb_q.pop_front(); n_cmp++;
        if (bus.read_data_1 !== exp_v) begin n_err++; $display("FAIL resume_rd1: got %h want %h", bus.read_data_1, exp_v); end
        exp_v = sb_q.pop_front(); n_cmp++;
        if (bus.read_data_2 !== exp_v) begin n_err++; $display("FAIL resume_rd2: got %h want %h", bus.read_data_2, exp_v); end
    endtask

    initial begin
        reset_n            = 1'b0;
        bus.write_enable   = 1'b0;
        bus.address_read_1 = '0;
        bus.address_read_2 = '0;
        bus.address_write  = '0;
        bus.write_data     = '0;
        repeat (2) @(posedge clock);
        test_reset();
        test_write_all();
        test_read_pairs();
        test_sweep(1'b0);
        test_zero_reg();
        test_write_disable();
        test_same_cycle();
        test_async_reset();
        test_resume();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
